// File: rtl/address_register_file_gen.sv
// Address register file: PC / AR / SP plus general registers, two combinational read ports,
// PC auto-increment and a bounds-checked SP with a sticky fault. Optional macro: ARF_WRAP_FLAG_EN.
module address_register_file_gen #(
  parameter int              WIDTH     = 16,
  parameter int              NUM_REGS  = 4,
  parameter int              SEL_W     = 2,
  parameter logic [WIDTH-1:0] STACK_TOP = 16'hFFFF,
  parameter logic [WIDTH-1:0] STACK_BOT = 16'h0100
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [WIDTH-1:0]    I,
  input  logic [2:0]          FunSel,
  input  logic [NUM_REGS-1:0] RegSel,
  input  logic                PCInc,
  input  logic                ClrFault,
  input  logic [SEL_W-1:0]    OutCSel,
  input  logic [SEL_W-1:0]    OutDSel,
  output logic [WIDTH-1:0]    OutC,
  output logic [WIDTH-1:0]    OutD,
`ifdef ARF_WRAP_FLAG_EN
  output logic [NUM_REGS-1:0] WrapFlags,
`endif
  output logic                StackFault
);

  localparam int H      = WIDTH / 2;
  localparam int PC_IDX = 0;
  localparam int SP_IDX = 2;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic             fault_q;
  logic             fault_d;
  logic             blk_s;

  // Next-state for every register; PCInc only acts when PC itself is not enabled.
  always_comb begin
    blk_s = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = regs_q[k];
      if (!RegSel[k]) begin
        case (FunSel)
          3'b000: begin
            if (k == SP_IDX && regs_q[k] == STACK_BOT) blk_s = 1'b1;
            else regs_d[k] = regs_q[k] - ONE;
          end
          3'b001: begin
            if (k == SP_IDX && regs_q[k] == STACK_TOP) blk_s = 1'b1;
            else regs_d[k] = regs_q[k] + ONE;
          end
          3'b010:  regs_d[k] = I;
          3'b011:  regs_d[k] = ZERO;
          3'b100:  regs_d[k] = {{(WIDTH-H){1'b0}}, I[H-1:0]};
          3'b101:  regs_d[k] = {regs_q[k][WIDTH-1:H], I[H-1:0]};
          3'b110:  regs_d[k] = {I[H-1:0], regs_q[k][H-1:0]};
          3'b111:  regs_d[k] = {{(WIDTH-H){I[H-1]}}, I[H-1:0]};
          default: regs_d[k] = regs_q[k];
        endcase
      end else if (k == PC_IDX && PCInc) begin
        regs_d[k] = regs_q[k] + ONE;
      end else begin
        regs_d[k] = regs_q[k];
      end
    end
  end

  // A newly blocked SP step outranks a same-cycle clear request.
  always_comb begin
    if (blk_s)         fault_d = 1'b1;
    else if (ClrFault) fault_d = 1'b0;
    else               fault_d = fault_q;
  end

  // Register state; SP resets to the top of the stack.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= (k == SP_IDX) ? STACK_TOP : ZERO;
      fault_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= regs_d[k];
      fault_q <= fault_d;
    end
  end

`ifdef ARF_WRAP_FLAG_EN
  logic [NUM_REGS-1:0] wrap_q;
  logic [NUM_REGS-1:0] wrap_d;

  // Wrap flags: set by a wrapping step, cleared by any load/clear of that register.
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      wrap_d[k] = wrap_q[k];
      if (!RegSel[k]) begin
        case (FunSel)
          3'b000: begin
            if (!(k == SP_IDX && regs_q[k] == STACK_BOT) && regs_q[k] == ZERO) wrap_d[k] = 1'b1;
            else wrap_d[k] = wrap_q[k];
          end
          3'b001: begin
            if (!(k == SP_IDX && regs_q[k] == STACK_TOP) && regs_q[k] == ONES) wrap_d[k] = 1'b1;
            else wrap_d[k] = wrap_q[k];
          end
          default: wrap_d[k] = 1'b0;
        endcase
      end else if (k == PC_IDX && PCInc && regs_q[k] == ONES) begin
        wrap_d[k] = 1'b1;
      end else begin
        wrap_d[k] = wrap_q[k];
      end
    end
  end

  // Wrap flag state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) wrap_q <= {NUM_REGS{1'b0}};
    else       wrap_q <= wrap_d;
  end

  assign WrapFlags = wrap_q;
`endif

  // Read ports; an out-of-range select falls back to PC.
  always_comb begin
    if (32'(OutCSel) < NUM_REGS) OutC = regs_q[OutCSel];
    else                         OutC = regs_q[PC_IDX];
    if (32'(OutDSel) < NUM_REGS) OutD = regs_q[OutDSel];
    else                         OutD = regs_q[PC_IDX];
  end

  assign StackFault = fault_q;

endmodule

// File: tb/tb_address_register_file_gen.sv
// Randomized + directed bench for address_register_file_gen (4- and 3-register instances)
// with a queue-based scoreboard fed by an arithmetic reference model.
module tb_address_register_file_gen;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] I = 16'h0000;
  logic [2:0]  FunSel = 3'b000;
  logic [3:0]  RegSel = 4'b1111;
  logic        PCInc = 1'b0;
  logic        ClrFault = 1'b0;
  logic [1:0]  c4s = 2'd0, d4s = 2'd0, c3s = 2'd0, d3s = 2'd0;
  logic [15:0] oc4, od4, oc3, od3;
  logic        sf4, sf3;
`ifdef ARF_WRAP_FLAG_EN
  logic [3:0]  wf4;
  logic [2:0]  wf3;
`endif

  int tests = 0;
  int fails = 0;

  always #5 Clock = ~Clock;

  address_register_file_gen #(.NUM_REGS(4)) u4 (
    .Clock(Clock), .Reset(Reset), .I(I), .FunSel(FunSel), .RegSel(RegSel), .PCInc(PCInc),
    .ClrFault(ClrFault), .OutCSel(c4s), .OutDSel(d4s), .OutC(oc4), .OutD(od4),
`ifdef ARF_WRAP_FLAG_EN
    .WrapFlags(wf4),
`endif
    .StackFault(sf4));

  address_register_file_gen #(.NUM_REGS(3)) u3 (
    .Clock(Clock), .Reset(Reset), .I(I), .FunSel(FunSel), .RegSel(RegSel[2:0]), .PCInc(PCInc),
    .ClrFault(ClrFault), .OutCSel(c3s), .OutDSel(d3s), .OutC(oc3), .OutD(od3),
`ifdef ARF_WRAP_FLAG_EN
    .WrapFlags(wf3),
`endif
    .StackFault(sf3));

  typedef struct {
    logic [15:0] c4, d4, c3, d3;
    logic        f4, f3;
    logic [3:0]  w4;
    logic [2:0]  w3;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: index 0 = four-register build, index 1 = three-register build
  logic [15:0] mm [2][4];
  logic        ff [2];
  logic [3:0]  ww [2];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 4; k++) mm[u][k] = (k == 2) ? 16'hFFFF : 16'h0000;
      ff[u] = 1'b0;
      ww[u] = 4'b0000;
    end
  endtask

  task automatic model_step(input logic [2:0] fs, input logic [3:0] rs, input logic [15:0] d,
                            input logic pci, input logic clr);
    int n, v, lo;
    bit blk;
    lo = int'(d) % 256;
    for (int u = 0; u < 2; u++) begin
      n = (u == 0) ? 4 : 3;
      blk = 1'b0;
      for (int k = 0; k < n; k++) begin
        v = int'(mm[u][k]);
        if (!rs[k]) begin
          case (fs)
            3'd0: if (k == 2 && v == 256) blk = 1'b1;
                  else begin if (v == 0) ww[u][k] = 1'b1; mm[u][k] = 16'((v + 65535) % 65536); end
            3'd1: if (k == 2 && v == 65535) blk = 1'b1;
                  else begin if (v == 65535) ww[u][k] = 1'b1; mm[u][k] = 16'((v + 1) % 65536); end
            3'd2: mm[u][k] = d;
            3'd3: mm[u][k] = 16'h0000;
            3'd4: mm[u][k] = 16'(lo);
            3'd5: mm[u][k] = 16'((v / 256) * 256 + lo);
            3'd6: mm[u][k] = 16'(lo * 256 + v % 256);
            default: mm[u][k] = 16'((lo >= 128) ? lo + 65280 : lo);
          endcase
          if (fs >= 3'd2) ww[u][k] = 1'b0;
        end else if (k == 0 && pci) begin
          if (v == 65535) ww[u][k] = 1'b1;
          mm[u][k] = 16'((v + 1) % 65536);
        end
      end
      if (blk) ff[u] = 1'b1;
      else if (clr) ff[u] = 1'b0;
    end
  endtask

  function automatic logic [15:0] rd(input int u, input logic [1:0] sel);
    int n;
    n = (u == 0) ? 4 : 3;
    return (int'(sel) < n) ? mm[u][sel] : mm[u][0];
  endfunction

  // Apply one operation between edges and queue what the DUT must show after the next edge
  task automatic drv(input logic [2:0] fs, input logic [3:0] rs, input logic [15:0] d,
                     input logic pci, input logic clr,
                     input logic [1:0] cs, input logic [1:0] ds,
                     input logic [1:0] cs3, input logic [1:0] ds3);
    exp_t e;
    @(negedge Clock);
    FunSel = fs; RegSel = rs; I = d; PCInc = pci; ClrFault = clr;
    c4s = cs; d4s = ds; c3s = cs3; d3s = ds3;
    model_step(fs, rs, d, pci, clr);
    e.c4 = rd(0, cs);  e.d4 = rd(0, ds);
    e.c3 = rd(1, cs3); e.d3 = rd(1, ds3);
    e.f4 = ff[0]; e.f3 = ff[1];
    e.w4 = ww[0]; e.w3 = ww[1][2:0];
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic pci, input logic clr, input logic [1:0] cs, input logic [1:0] ds);
    drv(3'd0, 4'b1111, 16'h0000, pci, clr, cs, ds, 2'd3, 2'd2);
  endtask

  // Monitor: compares the DUT against the oldest queued expectation after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("OutC4", oc4, e.c4);
        chk("OutD4", od4, e.d4);
        chk("OutC3", oc3, e.c3);
        chk("OutD3", od3, e.d3);
        chk("Fault4", {15'd0, sf4}, {15'd0, e.f4});
        chk("Fault3", {15'd0, sf3}, {15'd0, e.f3});
`ifdef ARF_WRAP_FLAG_EN
        chk("Wrap4", {12'd0, wf4}, {12'd0, e.w4});
        chk("Wrap3", {13'd0, wf3}, {13'd0, e.w3});
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] picks [5];
    logic [15:0] dv;
    logic [3:0]  rs;
    picks[0] = 16'hFFFF; picks[1] = 16'hFFFE; picks[2] = 16'h0100;
    picks[3] = 16'h0101; picks[4] = 16'h0000;
    model_reset();
    #1;
    chk("rst_fault4", {15'd0, sf4}, 16'h0000);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;

    // Reset mid-stream
    drv(3'd2, 4'b1101, 16'h1234, 1'b0, 1'b0, 2'd1, 2'd2, 2'd1, 2'd2);
    @(negedge Clock);
    FunSel = 3'd1; RegSel = 4'b0000;
    #2 Reset = 1'b1;
    #1;
    chk("rst_AR", oc4, 16'h0000);
    chk("rst_SP", od4, 16'hFFFF);
    chk("rst_SF", {15'd0, sf4}, 16'h0000);
    model_reset();
    @(negedge Clock);
    RegSel = 4'b1111;
    Reset = 1'b0;

    // PC wrap via PCInc, then a load beats PCInc
    drv(3'd2, 4'b1110, 16'hFFFE, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 2'd1);
    idle(1'b1, 1'b0, 2'd0, 2'd1);
    idle(1'b1, 1'b0, 2'd0, 2'd1);
    drv(3'd2, 4'b1110, 16'h0040, 1'b1, 1'b0, 2'd0, 2'd1, 2'd0, 2'd1);

    // SP at top: blocked inc, clear racing a fault, then clear alone
    drv(3'd2, 4'b1011, 16'hFFFF, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 2'd0);
    drv(3'd1, 4'b1011, 16'h0000, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 2'd0);
    drv(3'd1, 4'b1011, 16'h0000, 1'b0, 1'b1, 2'd2, 2'd0, 2'd2, 2'd0);
    idle(1'b0, 1'b1, 2'd2, 2'd0);

    // SP at bottom
    drv(3'd2, 4'b1011, 16'h0101, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 2'd0);
    repeat (3) drv(3'd0, 4'b1011, 16'h0000, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 2'd0);
    idle(1'b0, 1'b1, 2'd2, 2'd0);

    // Half-word operations on AR
    drv(3'd2, 4'b1101, 16'hABCD, 1'b0, 1'b0, 2'd1, 2'd2, 2'd1, 2'd2);
    drv(3'd5, 4'b1101, 16'h0012, 1'b0, 1'b0, 2'd1, 2'd2, 2'd1, 2'd2);
    drv(3'd6, 4'b1101, 16'h0012, 1'b0, 1'b0, 2'd1, 2'd2, 2'd1, 2'd2);
    drv(3'd7, 4'b1101, 16'h0080, 1'b0, 1'b0, 2'd1, 2'd2, 2'd1, 2'd2);
    drv(3'd4, 4'b1101, 16'h0080, 1'b0, 1'b0, 2'd1, 2'd2, 2'd1, 2'd2);

    // Read selects: SP / reg3, and an out-of-range select on the 3-register build
    drv(3'd2, 4'b0111, 16'h5A5A, 1'b1, 1'b0, 2'd2, 2'd3, 2'd3, 2'd2);
    idle(1'b1, 1'b0, 2'd2, 2'd3);

    // Randomized traffic, biased toward bound and wrap values
    for (int n = 0; n < 400; n++) begin
      dv = ($urandom_range(3) == 0) ? picks[$urandom_range(4)] : 16'($urandom);
      rs = ($urandom_range(1) == 0) ? ~(4'b0001 << $urandom_range(3)) : 4'($urandom);
      drv(3'($urandom), rs, dv, 1'($urandom), ($urandom_range(7) == 0),
          2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
    end

    repeat (3) @(posedge Clock);
    #2;
    chk("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
